gpio_input_unit: RTL
====================

# gpio_input_unit

Debounced switch-input peripheral for the CPU's memory-mapped I/O space; the read-side counterpart of the LED output unit. Synchronizes 8 asynchronous switch lines, debounces each bit independently, latches rising/falling edge events into sticky CPU-visible registers, and raises a level interrupt for enabled events. Software reads state and events through a 4-word register window and acknowledges events with write-1-to-clear.

## Interface
- WIDTH, 8, number of switch inputs (1..32)
- DB_CYCLES, 16, consecutive stable cycles required to accept a new level (>= 1)

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- switches_in  input  WIDTH  raw asynchronous switch levels
- addr  input  2  register select (word index)
- we  input  1  write strobe, sampled on rising clk edge
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr and registers
- irq  output  1  interrupt, level, active-high

## Operation
- Register map (unused upper bits read 0, writes ignored):
  - addr 0 STATE: debounced level, read-only
  - addr 1 RISE: sticky rising-edge events, W1C
  - addr 2 FALL: sticky falling-edge events, W1C
  - addr 3 MASK: interrupt enable per bit, read/write wdata[WIDTH-1:0]
- Synchronizer: two flops per bit, sync1 <= switches_in, sync2 <= sync1.
- Debounce, per bit, counter width clog2(DB_CYCLES), minimum 1 bit:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DB_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DB_CYCLES-1: stable <= sync2, counter <= 0.
  - Any return to the stable level before acceptance restarts the count; glitches shorter than DB_CYCLES cycles never reach STATE.
- Events: on the edge where stable goes 0->1, RISE bit set; 1->0, FALL bit set.
- W1C: write to addr 1/2 clears bits where wdata is 1; bits where wdata is 0 unchanged.
- Simultaneous set and W1C on the same bit in the same cycle: set wins (bit stays 1).
- Writes to addr 0 have no effect.
- irq = |((RISE | FALL) & MASK), combinational from registers; no internal pulse stretching.

## Timing
- Reset (rst_n low, immediate): sync1, sync2, stable, counters, RISE, FALL, MASK all 0; hence rdata reflects zeros for every addr and irq = 0.
- Reset mid-debounce discards count; no event is generated for the aborted transition.
- Latency: switches_in change setting up before edge 0 -> sync2 updates at edge 2 -> STATE and RISE/FALL update at edge 2+DB_CYCLES -> irq high after that edge if MASK bit set.
- Switch held high through reset release produces a RISE event at edge 2+DB_CYCLES after release (stable resets to 0).
- MASK write takes effect after the write edge; enabling a mask bit over an already-pending event asserts irq immediately after that edge.
- W1C of the last pending enabled event drops irq after the write edge, unless a new event sets in the same cycle.
- rdata is valid in the same cycle as addr; no read side effects.
- Independent bits may accept transitions in the same cycle; all corresponding event bits set together.

## Test plan
- Reset with switches_in=0x00, DB_CYCLES=16 -> all reads 0, irq=0; switches_in=0x01 steady -> STATE=0x01 and RISE=0x01 exactly 18 edges after change, not at edge 17.
- Bit 3 pulse high for 10 cycles, DB_CYCLES=16 -> STATE, RISE, FALL stay 0x00 throughout.
- MASK=0x01, bit 0 rises -> irq=1; write addr 1 wdata=0x01 -> RISE=0x00, irq=0 next cycle; write addr 1 wdata=0x02 beforehand leaves RISE=0x01.
- Bit 0 falls then W1C of FALL bit 0 issued on the exact edge the new fall is accepted -> FALL bit 0 remains 1.
- Event pending with MASK=0 -> irq=0; write MASK=0xFF -> irq=1 after write edge; write addr 0 wdata=0xFF -> STATE unchanged.
- rst_n asserted at debounce count 10 of a rising transition, released with input still high -> no event until 18 edges after release, then RISE bit set.

Source files
------------

// File: rtl/gpio_input_unit.sv
// rtl/gpio_input_unit.sv - debounced switch-input peripheral with sticky edge events and irq
//
// Purpose: synchronizes WIDTH asynchronous switch lines, debounces each bit
// independently, latches rising/falling edge events into sticky registers
// and raises a level interrupt for events enabled in MASK.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   switches_in  raw asynchronous switch levels
//   addr         register select: 0 STATE, 1 RISE (W1C), 2 FALL (W1C), 3 MASK
//   we           write strobe
//   wdata        write data
//   rdata        read data, combinational from addr and registers
//   irq          level interrupt, |((RISE | FALL) & MASK)
module gpio_input_unit #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  switches_in,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] mask;
  logic [CW-1:0]    cnt [WIDTH];

  // A bit is accepted when its synchronized level has differed from the
  // debounced level for DB_CYCLES consecutive cycles.
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign rise_set = accept & sync2;
  assign fall_set = accept & ~sync2;
  assign rise_clr = (we && addr == 2'd1) ? wdata[WIDTH-1:0] : '0;
  assign fall_clr = (we && addr == 2'd2) ? wdata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      mask   <= '0;
    end else begin
      sync1  <= switches_in;
      sync2  <= sync1;
      stable <= stable ^ accept;
      // Set is OR-ed in after the clear so a same-cycle event wins over W1C.
      rise   <= (rise & ~rise_clr) | rise_set;
      fall   <= (fall & ~fall_clr) | fall_set;
      if (we && addr == 2'd3) begin
        mask <= wdata[WIDTH-1:0];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[g] <= '0;
      end else if (sync2[g] == stable[g] || accept[g]) begin
        // Any return to the stable level restarts the count.
        cnt[g] <= '0;
      end else begin
        cnt[g] <= cnt[g] + CW'(1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[WIDTH-1:0] = stable;
      2'd1:    rdata[WIDTH-1:0] = rise;
      2'd2:    rdata[WIDTH-1:0] = fall;
      default: rdata[WIDTH-1:0] = mask;
    endcase
  end

  assign irq = |((rise | fall) & mask);

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:WIDTH];
  end

endmodule
